// File: rtl/ps2_kbd_ctrl_if.sv
// Bundle between the PS/2 receiver FIFO, the key-event controller and its consumer.
// master: the controller side; slave: the receiver FIFO plus event consumer side.
interface ps2_kbd_ctrl_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       shift_held;
  logic       ctrl_held;
  logic       caps_lock;
  logic [7:0] make_cnt;
  logic       ovf_sticky;
  logic       ovf_clr;

  modport master (
    input  kbd_data, kbd_ready, kbd_overflow, evt_ready, ovf_clr,
    output kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_brk,
           shift_held, ctrl_held, caps_lock, make_cnt, ovf_sticky
  );

  modport slave (
    output kbd_data, kbd_ready, kbd_overflow, evt_ready, ovf_clr,
    input  kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_brk,
           shift_held, ctrl_held, caps_lock, make_cnt, ovf_sticky
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: pops scan-code bytes from the receiver FIFO, folds E0/F0
// prefixes into single key events on a valid/ready port, and tracks Shift, Ctrl,
// Caps Lock, a make-event counter and a sticky overflow flag.
// Optional feature: define PS2_KBD_REPEAT_FILT_EN to drop typematic repeats of the
// most recently emitted make (the byte is still popped, no counter/caps effect).
module ps2_kbd_ctrl (
  input logic            clk,
  input logic            clrn,
  ps2_kbd_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t     r_state;
  logic       r_nextN;
  logic       r_evtValid;
  logic [7:0] r_evtCode;
  logic       r_evtExt;
  logic       r_evtBrk;
  logic       r_shift;
  logic       r_ctrl;
  logic       r_caps;
  logic [7:0] r_makeCnt;
  logic       r_ovf;
  logic       r_brkPend;
  logic       r_extPend;

  logic w_take;
  logic w_isBrkPfx;
  logic w_isExtPfx;
  logic w_isMake;
  logic w_keyByte;
  logic w_drop;
  logic w_emit;

  // A byte is consumed only from IDLE and only when no event is waiting downstream.
  assign w_take     = (r_state == IDLE) && bus.kbd_ready && !r_evtValid;
  assign w_isBrkPfx = (bus.kbd_data == 8'hF0);
  assign w_isExtPfx = (bus.kbd_data == 8'hE0);
  assign w_isMake   = !r_brkPend;
  assign w_keyByte  = w_take && !w_isBrkPfx && !w_isExtPfx;
  assign w_emit     = w_keyByte && !w_drop;

`ifdef PS2_KBD_REPEAT_FILT_EN
  logic       r_heldValid;
  logic [7:0] r_heldCode;
  logic       r_heldExt;

  assign w_drop = w_isMake && r_heldValid && (r_heldCode == bus.kbd_data) &&
                  (r_heldExt == r_extPend);

  // Remember the last emitted make so typematic repeats of it can be suppressed.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_heldValid <= 1'b0;
      r_heldCode  <= 8'h00;
      r_heldExt   <= 1'b0;
    end else if (w_emit) begin
      if (w_isMake) begin
        r_heldValid <= 1'b1;
        r_heldCode  <= bus.kbd_data;
        r_heldExt   <= r_extPend;
      end else if (r_heldValid && (r_heldCode == bus.kbd_data) &&
                   (r_heldExt == r_extPend)) begin
        r_heldValid <= 1'b0;
      end
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  // Pop sequencer, prefix folding, event register, modifier tracking and overflow latch.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= IDLE;
      r_nextN    <= 1'b1;
      r_evtValid <= 1'b0;
      r_evtCode  <= 8'h00;
      r_evtExt   <= 1'b0;
      r_evtBrk   <= 1'b0;
      r_shift    <= 1'b0;
      r_ctrl     <= 1'b0;
      r_caps     <= 1'b0;
      r_makeCnt  <= 8'h00;
      r_ovf      <= 1'b0;
      r_brkPend  <= 1'b0;
      r_extPend  <= 1'b0;
    end else begin
      if (bus.kbd_overflow)
        r_ovf <= 1'b1;
      else if (bus.ovf_clr)
        r_ovf <= 1'b0;

      case (r_state)
        IDLE: if (w_take) begin
          r_state <= POP;
          r_nextN <= 1'b0;
        end
        POP: begin
          r_state <= GAP;
          r_nextN <= 1'b1;
        end
        GAP: r_state <= IDLE;
        default: begin
          r_state <= IDLE;
          r_nextN <= 1'b1;
        end
      endcase

      if (w_take) begin
        if (w_isBrkPfx)
          r_brkPend <= 1'b1;
        else if (w_isExtPfx)
          r_extPend <= 1'b1;
        else begin
          r_brkPend <= 1'b0;
          r_extPend <= 1'b0;
        end
      end

      if (r_evtValid && bus.evt_ready)
        r_evtValid <= 1'b0;

      if (w_emit) begin
        r_evtValid <= 1'b1;
        r_evtCode  <= bus.kbd_data;
        r_evtExt   <= r_extPend;
        r_evtBrk   <= r_brkPend;
        if ((bus.kbd_data == 8'h12) || (bus.kbd_data == 8'h59))
          r_shift <= w_isMake;
        if (bus.kbd_data == 8'h14)
          r_ctrl <= w_isMake;
        if (w_isMake && !r_extPend && (bus.kbd_data == 8'h58))
          r_caps <= ~r_caps;
        if (w_isMake)
          r_makeCnt <= r_makeCnt + 8'd1;
      end
    end
  end

  assign bus.kbd_nextdata_n = r_nextN;
  assign bus.evt_valid      = r_evtValid;
  assign bus.evt_code       = r_evtCode;
  assign bus.evt_ext        = r_evtExt;
  assign bus.evt_brk        = r_evtBrk;
  assign bus.shift_held     = r_shift;
  assign bus.ctrl_held      = r_ctrl;
  assign bus.caps_lock      = r_caps;
  assign bus.make_cnt       = r_makeCnt;
  assign bus.ovf_sticky     = r_ovf;

endmodule
